// File: rtl/minifloat_accum.sv
// minifloat_accum: decode a stream of 7-bit minifloat codes and hand off a saturating per-packet sum
module minifloat_accum #(
  parameter int SUM_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       in_code,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [SUM_W-1:0] sum_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             ovf_out,
  output logic             sum_valid,
  input  logic             sum_ready
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t r_state, w_next;
  logic [SUM_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_ovf, w_ovf_nxt, w_accept;
  logic [10:0] w_val;
  logic [2:0] w_shift;
  logic [SUM_W:0] w_sum;
  assign w_shift   = in_code[6:4] - 3'd1;
  assign w_val     = in_code[6:4] == 3'd0 ? {7'd0, in_code[3:0]} : 11'({1'b1, in_code[3:0]}) << w_shift;
  assign w_sum     = {1'b0, r_acc} + (SUM_W+1)'(w_val);
  assign w_acc_nxt = w_sum[SUM_W] ? '1 : w_sum[SUM_W-1:0];
  assign w_ovf_nxt = r_ovf | w_sum[SUM_W];
  assign w_cnt_nxt = &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
  assign in_ready  = r_state == ACC;
  assign sum_valid = r_state == HOLD;
  assign w_accept  = in_valid & in_ready;
  // next state: leave ACC on an accepted last beat, leave HOLD when downstream takes the result
  always_comb begin
    w_next = r_state;
    if (r_state == ACC) w_next = w_accept && in_last ? HOLD : ACC;
    else w_next = sum_ready ? ACC : HOLD;
  end
  // accumulate accepted beats, capture the result on the last beat, clear on handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      sum_out <= '0;
      cnt_out <= '0;
      ovf_out <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
        if (in_last) begin
          sum_out <= w_acc_nxt;
          cnt_out <= w_cnt_nxt;
          ovf_out <= w_ovf_nxt;
        end
      end else if (r_state == HOLD && sum_ready) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end
  end
endmodule
